// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register map, CTRL bit positions, channel indices and the
// run-state encoding shared by the RGB PWM sequencer files.
package rgb_pwm_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_DUTY     = 2'd2;
    localparam logic [1:0] REG_FADE     = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FADE   = 1;

    localparam int DUTY_FIELD_BITS = 8;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    function automatic logic [DUTY_FIELD_BITS-1:0] duty_field(input logic [23:0] duty,
                                                              input channel_e ch);
        return duty[DUTY_FIELD_BITS*int'(ch) +: DUTY_FIELD_BITS];
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one colour channel -- live duty register, optional fade
// stepping toward the target, and the registered counter compare.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                load,
    input  logic                fade_mode,
    input  logic                fade_step,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cur_duty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_duty <= '0;
            pwm      <= 1'b0;
        end else if (!enable) begin
            cur_duty <= '0;
            pwm      <= 1'b0;
        end else begin
            // load is only high on a period boundary (or the run start), so
            // the compare never sees a duty change mid-period
            if (load) begin
                if (!fade_mode) begin
                    cur_duty <= target;
                end else if (fade_step && (cur_duty < target)) begin
                    cur_duty <= cur_duty + 1'b1;
                end else if (fade_step && (cur_duty > target)) begin
                    cur_duty <= cur_duty - 1'b1;
                end
            end
            pwm <= (pwm_cnt < cur_duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: register port, prescaler, PWM period counter and fade
// divider driving three PWM channels. Fade engine built only with RGB_PWM_FADE_EN.
module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        r_pwm,
    output logic        g_pwm,
    output logic        b_pwm
);

    // state   | meaning
    // ST_IDLE | counters and duties held at 0, outputs low
    // ST_RUN  | prescaler and period counter running

    run_state_e                 state;
    logic                       ctrl_enable;
    logic [PRESCALE_BITS-1:0]   prescale;
    logic [23:0]                duty;
    logic [PRESCALE_BITS-1:0]   pre_cnt;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic                       access;
    logic                       tick;
    logic                       boundary;
    logic                       start;
    logic                       load;
    logic                       fade_mode;
    logic                       fade_step;
    logic [31:0]                rd_word;
    logic [2:0]                 pwm_vec;
    logic                       unused_wdata;

`ifdef RGB_PWM_FADE_EN
    logic                       ctrl_fade;
    logic [7:0]                 fade_div;
    logic [7:0]                 fade_cnt;
`endif

    assign access       = bus_stb & ~bus_ack;
    assign unused_wdata = &{1'b0, bus_wdata[31:24]};

    always_comb begin
        rd_word = '0;
        case (bus_addr)
            REG_CTRL: begin
                rd_word[CTRL_ENABLE] = ctrl_enable;
`ifdef RGB_PWM_FADE_EN
                rd_word[CTRL_FADE] = ctrl_fade;
`endif
            end
            REG_PRESCALE: rd_word[PRESCALE_BITS-1:0] = prescale;
            REG_DUTY:     rd_word[23:0] = duty;
            REG_FADE: begin
`ifdef RGB_PWM_FADE_EN
                rd_word[7:0] = fade_div;
`else
                rd_word = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_ack     <= 1'b0;
            bus_rdata   <= '0;
            ctrl_enable <= 1'b0;
            prescale    <= '0;
            duty        <= '0;
`ifdef RGB_PWM_FADE_EN
            ctrl_fade   <= 1'b0;
            fade_div    <= '0;
`endif
        end else begin
            bus_ack   <= access;
            bus_rdata <= '0;
            if (access && bus_we) begin
                case (bus_addr)
                    REG_CTRL: begin
                        ctrl_enable <= bus_wdata[CTRL_ENABLE];
`ifdef RGB_PWM_FADE_EN
                        ctrl_fade <= bus_wdata[CTRL_FADE];
`endif
                    end
                    REG_PRESCALE: prescale <= bus_wdata[PRESCALE_BITS-1:0];
                    REG_DUTY:     duty <= bus_wdata[23:0];
                    REG_FADE: begin
`ifdef RGB_PWM_FADE_EN
                        fade_div <= bus_wdata[7:0];
`endif
                    end
                endcase
            end
            if (access && !bus_we) begin
                bus_rdata <= rd_word;
            end
        end
    end

    // >= rather than == so a PRESCALE shrunk below pre_cnt wraps at once
    assign tick     = (state == ST_RUN) && ctrl_enable && (pre_cnt >= prescale);
    assign boundary = tick && (pwm_cnt == {PWM_BITS{1'b1}});
    assign start    = (state == ST_IDLE) && ctrl_enable;
    assign load     = start | boundary;

`ifdef RGB_PWM_FADE_EN
    assign fade_mode = ctrl_fade;
    assign fade_step = boundary && ctrl_fade && (fade_cnt >= fade_div);
`else
    assign fade_mode = 1'b0;
    assign fade_step = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
            pwm_cnt <= '0;
`ifdef RGB_PWM_FADE_EN
            fade_cnt <= '0;
`endif
        end else if (!ctrl_enable) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
            pwm_cnt <= '0;
`ifdef RGB_PWM_FADE_EN
            fade_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_RUN;
                    pre_cnt <= '0;
                    pwm_cnt <= '0;
`ifdef RGB_PWM_FADE_EN
                    fade_cnt <= '0;
`endif
                end
                ST_RUN: begin
                    if (tick) begin
                        pre_cnt <= '0;
                        pwm_cnt <= pwm_cnt + 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
`ifdef RGB_PWM_FADE_EN
                    if (boundary) begin
                        fade_cnt <= fade_step ? 8'd0 : fade_cnt + 8'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [DUTY_FIELD_BITS-1:0] target_full;
        assign target_full = duty_field(duty, channel_e'(i));

        rgb_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_channel (
            .clk      (clk),
            .resetn   (resetn),
            .enable   (ctrl_enable),
            .load     (load),
            .fade_mode(fade_mode),
            .fade_step(fade_step),
            .target   (target_full[PWM_BITS-1:0]),
            .pwm_cnt  (pwm_cnt),
            .pwm      (pwm_vec[i])
        );
    end

    assign r_pwm = pwm_vec[CH_R];
    assign g_pwm = pwm_vec[CH_G];
    assign b_pwm = pwm_vec[CH_B];

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: randomized register and PWM-waveform checks against a
// period-level reference model. Fade scenarios run only with RGB_PWM_FADE_EN.
module tb_rgb_pwm_sequencer;
    import rgb_pwm_pkg::*;

    localparam int PERIOD = 256;
`ifdef RGB_PWM_FADE_EN
    localparam int unsigned CTRL_MASK = 32'h3;
    localparam int unsigned FADE_MASK = 32'hFF;
`else
    localparam int unsigned CTRL_MASK = 32'h1;
    localparam int unsigned FADE_MASK = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bus_stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        r_pwm;
    logic        g_pwm;
    logic        b_pwm;

    int n_checks = 0;
    int n_errors = 0;
    int last_ack = 0;
    logic [2:0] hist[$];

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(
        .PWM_BITS(8),
        .PRESCALE_BITS(16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus_stb  (bus_stb),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .r_pwm    (r_pwm),
        .g_pwm    (g_pwm),
        .b_pwm    (b_pwm)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        hist.push_back({b_pwm, g_pwm, r_pwm});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_hist(input int n);
        while (hist.size() < n) step();
    endtask

    task automatic bus_access(input logic we, input logic [1:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata);
        int waited = 0;
        bus_stb   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        do begin
            step();
            waited++;
        end while (!bus_ack && waited < 20);
        check("ack_latency", waited, 1);
        rdata    = bus_rdata;
        last_ack = hist.size() - 1;
        bus_stb  = 1'b0;
        bus_we   = 1'b0;
        step();
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_access(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        bus_access(1'b0, addr, 32'h0, data);
    endtask

    function automatic int field(input int unsigned duty, input int ch);
        return int'((duty >> (8 * ch)) & 32'hFF);
    endfunction

    // Reference: in period p the channel is high for the first duty*(pre+1)
    // clocks, low for the rest.
    task automatic check_period(input string tag, input int base, input int p, input int pre,
                                input int dr, input int dg, input int db);
        int len;
        int d[3];
        int ok[3];
        logic [2:0] s;
        len = PERIOD * (pre + 1);
        d[0] = dr; d[1] = dg; d[2] = db;
        ok[0] = 0; ok[1] = 0; ok[2] = 0;
        wait_hist(base + (p + 1) * len);
        for (int j = 0; j < len; j++) begin
            s = hist[base + p * len + j];
            for (int c = 0; c < 3; c++)
                if (s[c] == (j < d[c] * (pre + 1))) ok[c]++;
        end
        check($sformatf("%s_p%0d_r", tag, p), ok[0], len);
        check($sformatf("%s_p%0d_g", tag, p), ok[1], len);
        check($sformatf("%s_p%0d_b", tag, p), ok[2], len);
    endtask

    initial begin
        logic [31:0] rdata;
        int unsigned v;
        int unsigned masks[4];
        int pre;
        int base;
        int hi;
        int unsigned duty_v;
        int unsigned duty_new;
        int j;
        int acks;

        masks[0] = CTRL_MASK;
        masks[1] = 32'hFFFF;
        masks[2] = 32'hFF_FFFF;
        masks[3] = FADE_MASK;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        step();

        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rdata);
            check($sformatf("reset_reg%0d", a), rdata, 0);
        end

        wr(REG_DUTY, 32'h00FF_FFFF);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (r_pwm | g_pwm | b_pwm) hi++;
        end
        check("idle_outputs_low", hi, 0);

        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < 4; a++) begin
                v = $urandom;
                wr(2'(a), v);
                rd(2'(a), rdata);
                check($sformatf("readback_reg%0d", a), rdata, v & masks[a]);
            end
        end
        wr(REG_CTRL, 0);
        wr(REG_FADE, 0);

        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                pre = 0;
                duty_v = 32'h00FF_8000;
            end else begin
                pre = $urandom_range(0, 2);
                duty_v = $urandom & 32'hFF_FFFF;
            end
            wr(REG_CTRL, 0);
            wr(REG_PRESCALE, pre);
            wr(REG_DUTY, duty_v);
            wr(REG_CTRL, 1);
            base = last_ack + 2;
            for (int p = 0; p < 2; p++)
                check_period($sformatf("run%0d", it), base, p, pre,
                             field(duty_v, 0), field(duty_v, 1), field(duty_v, 2));
        end

        duty_v   = ($urandom & 32'hFF_FF00) | 32'd64;
        duty_new = (duty_v & 32'hFF_FF00) | 32'd192;
        wr(REG_CTRL, 0);
        wr(REG_PRESCALE, 3);
        wr(REG_DUTY, duty_v);
        wr(REG_CTRL, 1);
        base = last_ack + 2;
        steps(100);
        wr(REG_DUTY, duty_new);
        check_period("midwrite", base, 0, 3, 64, field(duty_v, 1), field(duty_v, 2));
        check_period("midwrite", base, 1, 3, 192, field(duty_v, 1), field(duty_v, 2));

        wr(REG_CTRL, 0);
        wr(REG_PRESCALE, 0);
        duty_v = ($urandom & 32'hFF_00FF) | (32'd200 << 8);
        wr(REG_DUTY, duty_v);
        wr(REG_CTRL, 1);
        base = last_ack + 2;
        steps(50);
        wr(REG_CTRL, 0);
        j = last_ack - base;
        check("disable_ack_g", hist[last_ack][1], ((j % PERIOD) < 200) ? 1 : 0);
        check("disable_next_all", hist[last_ack + 1], 0);
        wr(REG_CTRL, 1);
        base = last_ack + 2;
        check_period("reenable", base, 0, 0, field(duty_v, 0), 200, field(duty_v, 2));

`ifdef RGB_PWM_FADE_EN
        wr(REG_CTRL, 0);
        wr(REG_PRESCALE, 0);
        wr(REG_FADE, 1);
        duty_v = 32'd4 | (32'($urandom_range(0, 6)) << 8);
        wr(REG_DUTY, duty_v);
        wr(REG_CTRL, 3);
        base = last_ack + 2;
        for (int p = 0; p < 12; p++)
            check_period("fade", base, p, 0, (p / 2 < 4) ? p / 2 : 4,
                         (p / 2 < field(duty_v, 1)) ? p / 2 : field(duty_v, 1), 0);
        wr(REG_CTRL, 0);
        wr(REG_CTRL, 3);
        base = last_ack + 2;
        for (int p = 0; p < 3; p++)
            check_period("fade_restart", base, p, 0, p / 2,
                         (p / 2 < field(duty_v, 1)) ? p / 2 : field(duty_v, 1), 0);
`endif

        wr(REG_CTRL, 0);
        wr(REG_PRESCALE, 32'h1234);
        bus_stb   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = REG_DUTY;
        bus_wdata = 32'h00AB_CDEF;
        #1 resetn = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_ack) acks++;
        end
        check("reset_no_ack", acks, 0);
        resetn = 1'b1;
        j = 0;
        do begin
            step();
            j++;
        end while (!bus_ack && j < 20);
        check("held_stb_ack_latency", j, 1);
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_ack) acks++;
        end
        check("held_stb_single_ack", acks, 0);
        rd(REG_PRESCALE, rdata);
        check("reset_prescale", rdata, 0);
        rd(REG_CTRL, rdata);
        check("reset_ctrl", rdata, 0);
        rd(REG_DUTY, rdata);
        check("held_write_duty", rdata, 32'h00AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
